ps2_scancode_rx: RTL and testbench

//  PS/2 set-2 keyboard receiver. It deserialises raw ps2_clk/ps2_data frames, folds the E0/F0/E1 prefixes into whole key events,
//  and drives the 11-bit ps2_key event word consumed by the Spectrum keyboard matrix block.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_scancode_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scancode receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PFX_EXT    = 8'hE0;
   localparam logic [7:0] PFX_REL    = 8'hF0;
   localparam logic [7:0] PFX_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
   localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

   localparam int KEY_TGL = 10;
   localparam int KEY_PRS = 9;
   localparam int KEY_EXT = 8;

   // Bytes the keyboard sends as replies to host commands rather than as keys.
   function automatic logic is_dev_resp(input logic [7:0] b);
      logic r;
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: r = 1'b1;
         default:                                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one raw PS/2 line;
// emits the filtered level and a one-cycle strobe on its 1->0 transition.
module ps2_line_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);
   import ps2_pkg::*;

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic          r_fall;
   logic [CW-1:0] r_cnt;
   logic          w_sample;

   assign w_sample = r_sync[1];

   // The level flips only on the FILT_LEN-th consecutive disagreeing sample.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync  <= 2'b11;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync <= {r_sync[0], i_line};
         r_fall <= 1'b0;
         if (w_sample != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= w_sample;
               r_cnt   <= '0;
               r_fall  <= ~w_sample;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_level = r_level;
   assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 receiver: frame FSM, mid-frame watchdog and prefix folding into 11-bit key events.
// Optional build macro PS2_FAKE_SHIFT_FILTER_EN drops the E0 12 / E0 59 fake-shift events.
module ps2_scancode_rx #(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 56000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);
   import ps2_pkg::*;

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

   logic w_clk_lvl, w_clk_fall, w_data_lvl, w_data_fall;
   logic w_unused_lines;

   ps2_state_e r_state, w_state_nxt;
   logic [7:0]      r_shift;
   logic [2:0]      r_bitcnt;
   logic            r_par;
   logic [WD_W-1:0] r_wd;
   logic            w_byte_ok, w_bit_err, w_timeout;

   logic [10:0] r_key;
   logic        r_frame_err;
   logic        r_ext, r_rel;
   logic [2:0]  r_skip;
   logic        w_fake_shift;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .i_clk(clk_sys), .i_reset(reset), .i_line(ps2_clk_in),
      .o_level(w_clk_lvl), .o_fall(w_clk_fall)
   );

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
      .i_clk(clk_sys), .i_reset(reset), .i_line(ps2_data_in),
      .o_level(w_data_lvl), .o_fall(w_data_fall)
   );

   assign w_unused_lines = &{1'b0, w_clk_lvl, w_data_fall};

   // Frame state register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; a bit strobe takes precedence over watchdog expiry.
   always_comb begin
      w_state_nxt = r_state;
      w_byte_ok   = 1'b0;
      w_bit_err   = 1'b0;
      w_timeout   = 1'b0;
      if (w_clk_fall) begin
         case (r_state)
            ST_IDLE:   w_state_nxt = w_data_lvl ? ST_IDLE : ST_DATA;
            ST_DATA:   w_state_nxt = (r_bitcnt == 3'd7) ? ST_PARITY : ST_DATA;
            ST_PARITY: w_state_nxt = ST_STOP;
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (w_data_lvl && (^{r_shift, r_par})) begin
                  w_byte_ok = 1'b1;
               end else begin
                  w_bit_err = 1'b1;
               end
            end
            default:   w_state_nxt = ST_IDLE;
         endcase
      end else if ((r_state != ST_IDLE) && (r_wd == WD_MAX)) begin
         w_timeout   = 1'b1;
         w_state_nxt = ST_IDLE;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Shift register, bit counter, parity capture and watchdog counter.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_shift  <= 8'h00;
         r_bitcnt <= 3'd0;
         r_par    <= 1'b0;
         r_wd     <= '0;
      end else if (w_clk_fall) begin
         r_wd <= '0;
         case (r_state)
            ST_IDLE:   r_bitcnt <= 3'd0;
            ST_DATA: begin
               r_shift  <= {w_data_lvl, r_shift[7:1]};
               r_bitcnt <= r_bitcnt + 3'd1;
            end
            ST_PARITY: r_par <= w_data_lvl;
            default:   r_par <= r_par;
         endcase
      end else if ((r_state == ST_IDLE) || w_timeout) begin
         r_wd <= '0;
      end else begin
         r_wd <= r_wd + WD_W'(1);
      end
   end

`ifdef PS2_FAKE_SHIFT_FILTER_EN
   assign w_fake_shift = r_ext && ((r_shift == FAKE_SHIFT_L) || (r_shift == FAKE_SHIFT_R));
`else
   assign w_fake_shift = 1'b0;
`endif

   // Byte layer: prefixes, Pause swallowing, device replies and event emission.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_key       <= 11'h000;
         r_frame_err <= 1'b0;
         r_ext       <= 1'b0;
         r_rel       <= 1'b0;
         r_skip      <= 3'd0;
      end else begin
         r_frame_err <= w_bit_err | w_timeout;
         if (w_timeout) begin
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= 3'd0;
         end else if (w_byte_ok) begin
            if (r_skip != 3'd0) begin
               r_skip <= r_skip - 3'd1;
            end else if (r_shift == PFX_PAUSE) begin
               r_skip <= PAUSE_SKIP;
            end else if (r_shift == PFX_EXT) begin
               r_ext <= 1'b1;
            end else if (r_shift == PFX_REL) begin
               r_rel <= 1'b1;
            end else if (!r_ext && !r_rel && is_dev_resp(r_shift)) begin
               r_skip <= 3'd0;
            end else if (w_fake_shift) begin
               r_ext <= 1'b0;
               r_rel <= 1'b0;
            end else begin
               r_key <= {~r_key[KEY_TGL], ~r_rel, r_ext, r_shift};
               r_ext <= 1'b0;
               r_rel <= 1'b0;
            end
         end else begin
            r_skip <= r_skip;
         end
      end
   end

   assign ps2_key   = r_key;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised and directed bench for ps2_scancode_rx against a byte-level event model.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   // monitor state
   int          cyc = 0;
   int          err_cnt = 0, ev_cnt = 0, wide_err = 0, tgl_bad = 0, t_keychg = 0;
   logic        err_prev = 1'b0;
   logic [10:0] key_prev = 11'h000;

   // reference model state
   logic [10:0] m_key = 11'h000;
   logic        m_ext = 1'b0, m_rel = 1'b0;
   int          m_skip = 0, m_events = 0, m_errs = 0;
   int          t_fall = 0;

   ps2_scancode_rx #(.FILT_LEN(8), .TIMEOUT_CYC(2000)) dut (
      .clk_sys(clk), .reset(reset), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data),
      .ps2_key(ps2_key), .frame_err(frame_err)
   );

   always #500 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) begin
         err_cnt <= err_cnt + 1;
         if (err_prev) wide_err <= wide_err + 1;
      end
      err_prev <= frame_err;
      if (!reset && (ps2_key != key_prev)) begin
         ev_cnt   <= ev_cnt + 1;
         t_keychg <= cyc;
         if (ps2_key[10] == key_prev[10]) tgl_bad <= tgl_bad + 1;
      end
      key_prev <= ps2_key;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic fake;
      fake = 1'b0;
`ifdef PS2_FAKE_SHIFT_FILTER_EN
      fake = m_ext && (b == 8'h12 || b == 8'h59);
`endif
      if (m_skip != 0) m_skip--;
      else if (b == 8'hE1) m_skip = 7;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (!m_ext && !m_rel && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) m_skip = 0;
      else if (fake) begin m_ext = 1'b0; m_rel = 1'b0; end
      else begin
         m_key = {~m_key[10], ~m_rel, m_ext, b};
         m_events++;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      t_fall  = cyc;
      repeat (40) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input bit glitch);
      if (glitch) begin
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (20) @(negedge clk);
      end
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (10 + $urandom_range(0, 30)) @(negedge clk);
   endtask

   task automatic frame_chk(input logic [7:0] b, input bit bad);
      send_frame(b, bad, 1'b0);
      if (bad) m_errs++;
      else model_byte(b);
      check_val("key", {21'h0, ps2_key}, {21'h0, m_key});
      check_val("errs", err_cnt, m_errs);
      check_val("events", ev_cnt, m_events);
   endtask

   initial begin
      #150_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic [10:0] k0;
      int e0, r, t_err;
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check_val("rst_key", {21'h0, ps2_key}, 32'h0);
      check_val("rst_err", {31'h0, frame_err}, 32'h0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // 1: glitch before start bit, then 1C with correct parity
      k0 = m_key;
      send_frame(8'h1C, 1'b0, 1'b1);
      model_byte(8'h1C);
      check_val("t1_key", {21'h0, ps2_key}, {21'h0, ~k0[10], 1'b1, 1'b0, 8'h1C});
      check_val("t1_lat", ((t_keychg - t_fall) >= 8 && (t_keychg - t_fall) <= 16), 32'h1);
      check_val("t1_err", err_cnt, 32'h0);

      // 2: extended release
      e0 = m_events;
      frame_chk(8'hE0, 1'b0); frame_chk(8'hF0, 1'b0); frame_chk(8'h75, 1'b0);
      check_val("t2_key", {22'h0, ps2_key[9:0]}, {22'h0, 1'b0, 1'b1, 8'h75});
      check_val("t2_evt", ev_cnt - e0, 32'h1);
      frame_chk(8'h1C, 1'b0);
      check_val("t2_ext", {31'h0, ps2_key[8]}, 32'h0);

      // 3: parity error, then good frame
      k0 = ps2_key;
      frame_chk(8'h1C, 1'b1);
      check_val("t3_hold", {21'h0, ps2_key}, {21'h0, k0});
      frame_chk(8'h1B, 1'b0);
      check_val("t3_prs", {31'h0, ps2_key[9]}, 32'h1);

      // 4: watchdog abort after five data bits
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(i[0]);
      t_err = -1;
      for (int i = 0; i < 2600 && t_err < 0; i++) begin
         @(negedge clk);
         if (frame_err) t_err = cyc;
      end
      check_val("t4_timeout", (t_err - t_fall >= 2001 && t_err - t_fall <= 2030), 32'h1);
      m_errs++; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
      repeat (5) @(negedge clk);
      frame_chk(8'h29, 1'b0);

      // reset in the middle of a frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_val("t4_rst_key", {21'h0, ps2_key}, 32'h0);
      check_val("t4_rst_err", {31'h0, frame_err}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      m_key = 11'h000; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
      repeat (20) @(negedge clk);
      frame_chk(8'h1C, 1'b0);

      // 5: Pause sequence swallowed, device replies ignored
      e0 = m_events;
      frame_chk(8'hE1, 1'b0); frame_chk(8'h14, 1'b0); frame_chk(8'h77, 1'b0);
      frame_chk(8'hE1, 1'b0); frame_chk(8'hF0, 1'b0); frame_chk(8'h14, 1'b0);
      frame_chk(8'hF0, 1'b0); frame_chk(8'h77, 1'b0); frame_chk(8'h5A, 1'b0);
      check_val("t5_evt", ev_cnt - e0, 32'h1);
      check_val("t5_code", {24'h0, ps2_key[7:0]}, 32'h5A);
      e0 = ev_cnt;
      frame_chk(8'hAA, 1'b0); frame_chk(8'hFA, 1'b0);
      check_val("t5_resp", ev_cnt - e0, 32'h0);

      // 6: fake shift
      e0 = ev_cnt;
      frame_chk(8'hE0, 1'b0); frame_chk(8'h12, 1'b0);
      frame_chk(8'hE0, 1'b0); frame_chk(8'h6B, 1'b0);
`ifdef PS2_FAKE_SHIFT_FILTER_EN
      check_val("t6_evt", ev_cnt - e0, 32'h1);
`else
      check_val("t6_evt", ev_cnt - e0, 32'h2);
`endif
      check_val("t6_key", {23'h0, ps2_key[8:0]}, {23'h0, 1'b1, 8'h6B});

      // random byte stream
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 11);
         case (r)
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
            3: b = 8'hAA;
            4: b = 8'hFA;
            5: b = 8'h12;
            6: b = 8'h59;
            default: b = 8'($urandom_range(0, 255));
         endcase
         frame_chk(b, ($urandom_range(0, 9) == 0));
      end

      check_val("err_width", wide_err, 32'h0);
      check_val("toggle", tgl_bad, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
